// File: rtl/key_pkg.sv
// Shared gesture codes and per-key FSM state encodings for the key gesture decoder.
package key_pkg;

  localparam logic [1:0] EV_NONE   = 2'b00;
  localparam logic [1:0] EV_SINGLE = 2'b01;
  localparam logic [1:0] EV_DOUBLE = 2'b10;
  localparam logic [1:0] EV_LONG   = 2'b11;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_DOWN1 = 3'd1;
  localparam logic [2:0] ST_HOLD  = 3'd2;
  localparam logic [2:0] ST_GAP   = 3'd3;
  localparam logic [2:0] ST_DOWN2 = 3'd4;

endpackage

// File: rtl/key_debounce.sv
// Two-flop synchroniser and debounce for one active-low key; produces one-cycle
// press/release strobes when the clean level flips.
module key_debounce #(
  parameter int DEBOUNCE_MAX = 999_999,
  parameter int CNT_W        = 32
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key,
  output logic press_stb,
  output logic release_stb
);

  localparam logic [CNT_W-1:0] DB_LAST  = CNT_W'(DEBOUNCE_MAX);
  localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic             sync1_r, sync2_r, clean_r, press_r, release_r;
  logic [CNT_W-1:0] cnt_r;

  // Synchroniser, stability counter and clean-level flip with strobes
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1_r   <= 1'b1;
      sync2_r   <= 1'b1;
      clean_r   <= 1'b1;
      cnt_r     <= CNT_ZERO;
      press_r   <= 1'b0;
      release_r <= 1'b0;
    end else begin
      sync1_r   <= key;
      sync2_r   <= sync1_r;
      press_r   <= 1'b0;
      release_r <= 1'b0;
      if (sync2_r == clean_r) begin
        cnt_r <= CNT_ZERO;
      end else if (cnt_r == DB_LAST) begin
        cnt_r     <= CNT_ZERO;
        clean_r   <= sync2_r;
        press_r   <= ~sync2_r;
        release_r <= sync2_r;
      end else begin
        cnt_r <= cnt_r + CNT_ONE;
      end
    end
  end

  assign press_stb   = press_r;
  assign release_stb = release_r;

endmodule

// File: rtl/key_gesture.sv
// Multi-key gesture decoder: per-key single/double/long classification plus a
// fixed-priority serialised event port. Long press is built only with KEY_LONG_PRESS_EN.
module key_gesture
  import key_pkg::*;
#(
  parameter int NUM_KEYS     = 4,
  parameter int DEBOUNCE_MAX = 999_999,
  parameter int GAP_MAX      = 29_999_999,
  parameter int LONG_MAX     = 49_999_999,
  parameter int CNT_W        = 32
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic [NUM_KEYS-1:0]         keys,
  output logic [NUM_KEYS-1:0]         single_o,
  output logic [NUM_KEYS-1:0]         double_o,
  output logic [NUM_KEYS-1:0]         long_o,
  output logic                        ev_valid_o,
  output logic [$clog2(NUM_KEYS)-1:0] ev_key_o,
  output logic [1:0]                  ev_code_o,
  output logic                        ev_overrun_o
);

  localparam int KW = $clog2(NUM_KEYS);
  localparam logic [CNT_W-1:0] T_ZERO = {CNT_W{1'b0}};
  localparam logic [CNT_W-1:0] T_ONE  = CNT_W'(1);
  localparam logic [CNT_W-1:0] T_SAT  = {CNT_W{1'b1}};
  localparam logic [CNT_W-1:0] T_GAP  = CNT_W'(GAP_MAX);
  localparam logic [CNT_W-1:0] T_LONG = CNT_W'(LONG_MAX - 1);

  logic [NUM_KEYS-1:0]      press_s, release_s, drain_s, ovr_s;
  logic [NUM_KEYS-1:0][1:0] emit_s, slot_r;
  logic [NUM_KEYS-1:0]      single_r, double_r;
  logic                     ev_valid_r, ev_overrun_r, sel_valid_s;
  logic [KW-1:0]            ev_key_r, sel_key_s;
  logic [1:0]               ev_code_r, sel_code_s;

  for (genvar k = 0; k < NUM_KEYS; k++) begin : g_key
    logic [2:0]       state_r, state_s;
    logic [CNT_W-1:0] t_r, t_s, t_inc_s;
    logic [1:0]       code_s;

    key_debounce #(.DEBOUNCE_MAX(DEBOUNCE_MAX), .CNT_W(CNT_W)) u_deb (
      .clk        (clk),
      .rst_n      (rst_n),
      .key        (keys[k]),
      .press_stb  (press_s[k]),
      .release_stb(release_s[k])
    );

    // Gesture FSM next state, saturating timer and emitted code
    always_comb begin
      state_s = state_r;
      t_s     = t_r;
      code_s  = EV_NONE;
      t_inc_s = (t_r == T_SAT) ? t_r : t_r + T_ONE;
      case (state_r)
        ST_IDLE: begin
          if (press_s[k]) begin
            state_s = ST_DOWN1;
            t_s     = T_ZERO;
          end else begin
            state_s = ST_IDLE;
          end
        end
        ST_DOWN1: begin
          t_s = t_inc_s;
          if (release_s[k]) begin
            state_s = ST_GAP;
            t_s     = T_ZERO;
`ifdef KEY_LONG_PRESS_EN
          end else if (t_inc_s == T_LONG) begin
            state_s = ST_HOLD;
            code_s  = EV_LONG;
          end else begin
            state_s = ST_DOWN1;
          end
        end
        ST_HOLD: begin
          if (release_s[k]) begin
            state_s = ST_IDLE;
          end else begin
            state_s = ST_HOLD;
          end
        end
`else
          end else begin
            // Hold time is irrelevant here; keep the timer bounded.
            state_s = ST_DOWN1;
            t_s     = (t_r == T_LONG) ? t_r : t_inc_s;
          end
        end
`endif
        ST_GAP: begin
          t_s = t_inc_s;
          if (press_s[k]) begin
            state_s = ST_DOWN2;
          end else if (t_inc_s == T_GAP) begin
            state_s = ST_IDLE;
            code_s  = EV_SINGLE;
          end else begin
            state_s = ST_GAP;
          end
        end
        ST_DOWN2: begin
          if (release_s[k]) begin
            state_s = ST_IDLE;
            code_s  = EV_DOUBLE;
          end else begin
            state_s = ST_DOWN2;
          end
        end
        default: begin
          state_s = ST_IDLE;
          t_s     = T_ZERO;
        end
      endcase
    end

    // Per-key FSM state and timer registers
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        state_r <= ST_IDLE;
        t_r     <= T_ZERO;
      end else begin
        state_r <= state_s;
        t_r     <= t_s;
      end
    end

    assign emit_s[k] = code_s;
  end

  // Lowest-indexed full slot wins; flag slots drained or overwritten this cycle
  always_comb begin
    sel_valid_s = 1'b0;
    sel_key_s   = {KW{1'b0}};
    sel_code_s  = EV_NONE;
    for (int k = NUM_KEYS - 1; k >= 0; k--) begin
      if (slot_r[k] != EV_NONE) begin
        sel_valid_s = 1'b1;
        sel_key_s   = KW'(k);
        sel_code_s  = slot_r[k];
      end else begin
        sel_valid_s = sel_valid_s;
      end
    end
    for (int k = 0; k < NUM_KEYS; k++) begin
      drain_s[k] = sel_valid_s && (sel_key_s == KW'(k));
      ovr_s[k]   = (emit_s[k] != EV_NONE) && (slot_r[k] != EV_NONE) && !drain_s[k];
    end
  end

`ifdef KEY_LONG_PRESS_EN
  logic [NUM_KEYS-1:0] long_r;

  // Registered long-press pulses
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      long_r <= {NUM_KEYS{1'b0}};
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        long_r[k] <= (emit_s[k] == EV_LONG);
      end
    end
  end

  assign long_o = long_r;
`else
  assign long_o = {NUM_KEYS{1'b0}};
`endif

  // Registered pulses, pending slots and serialised event port
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      single_r     <= {NUM_KEYS{1'b0}};
      double_r     <= {NUM_KEYS{1'b0}};
      slot_r       <= {NUM_KEYS{EV_NONE}};
      ev_valid_r   <= 1'b0;
      ev_key_r     <= {KW{1'b0}};
      ev_code_r    <= EV_NONE;
      ev_overrun_r <= 1'b0;
    end else begin
      for (int k = 0; k < NUM_KEYS; k++) begin
        single_r[k] <= (emit_s[k] == EV_SINGLE);
        double_r[k] <= (emit_s[k] == EV_DOUBLE);
        // A new emit always lands in the slot, even when the old code is leaving now.
        if (emit_s[k] != EV_NONE) begin
          slot_r[k] <= emit_s[k];
        end else if (drain_s[k]) begin
          slot_r[k] <= EV_NONE;
        end else begin
          slot_r[k] <= slot_r[k];
        end
      end
      ev_valid_r   <= sel_valid_s;
      ev_key_r     <= sel_key_s;
      ev_code_r    <= sel_code_s;
      ev_overrun_r <= |ovr_s;
    end
  end

  assign single_o     = single_r;
  assign double_o     = double_r;
  assign ev_valid_o   = ev_valid_r;
  assign ev_key_o     = ev_key_r;
  assign ev_code_o    = ev_code_r;
  assign ev_overrun_o = ev_overrun_r;

endmodule

// File: tb/tb_key_gesture.sv
// Self-checking bench for key_gesture: gesture vector table, hand-written corner
// sequences and random key activity checked every cycle against a reference model.
module tb_key_gesture;

  localparam int NK = 4, DB = 3, GAP = 20, LONG = 40;
  localparam logic [1:0] C_NONE = 2'b00, C_SINGLE = 2'b01, C_DOUBLE = 2'b10, C_LONG = 2'b11;
`ifdef KEY_LONG_PRESS_EN
  localparam bit LONG_EN = 1'b1;
  localparam logic [1:0] HELD_CODE = C_LONG;
  localparam int HELD_LAT = 45;
`else
  localparam bit LONG_EN = 1'b0;
  localparam logic [1:0] HELD_CODE = C_SINGLE;
  localparam int HELD_LAT = 86;
`endif

  logic clk, rst_n;
  logic [NK-1:0] keys, single_o, double_o, long_o;
  logic ev_valid_o, ev_overrun_o;
  logic [1:0] ev_key_o, ev_code_o;

  key_gesture #(.NUM_KEYS(NK), .DEBOUNCE_MAX(DB), .GAP_MAX(GAP), .LONG_MAX(LONG), .CNT_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .keys(keys), .single_o(single_o), .double_o(double_o),
    .long_o(long_o), .ev_valid_o(ev_valid_o), .ev_key_o(ev_key_o), .ev_code_o(ev_code_o),
    .ev_overrun_o(ev_overrun_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_tests = 0, n_fail = 0, cyc = 0;

  typedef struct { int cyc; int key; logic [1:0] code; } rec_t;
  rec_t ev_q[$], pulse_q[$];

  typedef struct { string name; int key; int h1; int gp; int h2; int n_exp; logic [1:0] code; int lat; } vec_t;
  vec_t vecs[4];

  // Reference model state: raw-sample history, gesture bookkeeping by timestamps, pending slots
  logic [15:0] m_hist[NK];
  logic        m_clean[NK], m_pstb[NK], m_rstb[NK];
  int          m_n[NK], m_t0[NK], m_g0[NK];
  bit          m_down[NK], m_long[NK];
  logic [1:0]  m_slot[NK];
  logic [NK-1:0] e_single, e_double, e_long;
  logic        e_valid, e_ovr;
  logic [1:0]  e_key, e_code;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < NK; k++) begin
      m_hist[k] = 16'hFFFF; m_clean[k] = 1'b1; m_pstb[k] = 1'b0; m_rstb[k] = 1'b0;
      m_n[k] = 0; m_down[k] = 1'b0; m_long[k] = 1'b0; m_slot[k] = C_NONE;
    end
    e_single = '0; e_double = '0; e_long = '0;
    e_valid = 1'b0; e_key = 2'd0; e_code = C_NONE; e_ovr = 1'b0;
  endtask

  task automatic model_edge(input logic [NK-1:0] x);
    logic [1:0]  emit[NK];
    logic [15:0] mask, w;
    mask = (16'd1 << (DB + 1)) - 16'd1;
    for (int k = 0; k < NK; k++) begin
      emit[k] = C_NONE;
      // gesture rules act on strobes produced at the previous edge
      if (m_n[k] == 0) begin
        if (m_pstb[k]) begin m_n[k] = 1; m_down[k] = 1'b1; m_long[k] = 1'b0; m_t0[k] = cyc; end
      end else if (m_n[k] == 1 && m_down[k]) begin
        if (m_rstb[k]) begin
          if (m_long[k]) m_n[k] = 0;
          else begin m_down[k] = 1'b0; m_g0[k] = cyc; end
        end else if (LONG_EN && !m_long[k] && (cyc - m_t0[k] == LONG - 1)) begin
          emit[k] = C_LONG; m_long[k] = 1'b1;
        end
      end else if (m_n[k] == 1) begin
        if (m_pstb[k]) begin m_n[k] = 2; m_down[k] = 1'b1; end
        else if (cyc - m_g0[k] == GAP) begin emit[k] = C_SINGLE; m_n[k] = 0; end
      end else if (m_rstb[k]) begin
        emit[k] = C_DOUBLE; m_n[k] = 0;
      end
      // clean level flips once DB+1 consecutive synchronised samples disagree with it
      m_hist[k] = {m_hist[k][14:0], x[k]};
      w = (m_hist[k] >> 2) & mask;
      m_pstb[k] = m_clean[k] && (w == 16'd0);
      m_rstb[k] = !m_clean[k] && (w == mask);
      if (m_pstb[k] || m_rstb[k]) m_clean[k] = !m_clean[k];
      e_single[k] = (emit[k] == C_SINGLE);
      e_double[k] = (emit[k] == C_DOUBLE);
      e_long[k]   = (emit[k] == C_LONG);
    end
    e_valid = 1'b0; e_key = 2'd0; e_code = C_NONE; e_ovr = 1'b0;
    for (int k = 0; k < NK; k++) begin
      if (!e_valid && m_slot[k] != C_NONE) begin
        e_valid = 1'b1; e_key = 2'(k); e_code = m_slot[k]; m_slot[k] = C_NONE;
      end
    end
    for (int k = 0; k < NK; k++) begin
      if (emit[k] != C_NONE) begin
        if (m_slot[k] != C_NONE) e_ovr = 1'b1;
        m_slot[k] = emit[k];
      end
    end
  endtask

  // one clock: drive pressed mask p, advance model, compare all outputs, log pulses/events
  task automatic cycle(input logic [NK-1:0] p);
    keys = ~p;
    @(posedge clk);
    cyc++;
    if (rst_n) model_edge(~p);
    else model_reset();
    #1;
    chk($sformatf("outputs@%0d", cyc),
        {14'd0, single_o, double_o, long_o, ev_valid_o, ev_key_o, ev_code_o, ev_overrun_o},
        {14'd0, e_single, e_double, e_long, e_valid, e_key, e_code, e_ovr});
    for (int k = 0; k < NK; k++) begin
      if (single_o[k]) pulse_q.push_back('{cyc, k, C_SINGLE});
      if (double_o[k]) pulse_q.push_back('{cyc, k, C_DOUBLE});
      if (long_o[k])   pulse_q.push_back('{cyc, k, C_LONG});
    end
    if (ev_valid_o) ev_q.push_back('{cyc, int'(ev_key_o), ev_code_o});
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) cycle('0);
  endtask

  task automatic run_vec(input vec_t v);
    logic [NK-1:0] m;
    int s;
    m = 4'b0001 << v.key;
    idle(10);
    ev_q.delete(); pulse_q.delete();
    s = cyc + 1;
    for (int i = 0; i < v.h1; i++) cycle(m);
    if (v.gp > 0) begin
      for (int i = 0; i < v.gp; i++) cycle('0);
      for (int i = 0; i < v.h2; i++) cycle(m);
    end
    idle(80);
    chk({v.name, "_events"}, ev_q.size(), v.n_exp);
    chk({v.name, "_pulses"}, pulse_q.size(), v.n_exp);
    if (v.n_exp > 0 && ev_q.size() > 0 && pulse_q.size() > 0) begin
      chk({v.name, "_ev_code"}, ev_q[0].code, v.code);
      chk({v.name, "_ev_key"}, ev_q[0].key, v.key);
      chk({v.name, "_pulse_code"}, pulse_q[0].code, v.code);
      chk({v.name, "_pulse_lat"}, pulse_q[0].cyc - s, v.lat);
      chk({v.name, "_ev_after_pulse"}, ev_q[0].cyc - pulse_q[0].cyc, 1);
    end
  endtask

  initial begin
    int s;
    int rem[NK];
    logic [NK-1:0] lvl;

    vecs[0] = '{"single", 0, 10, 0, 0, 1, C_SINGLE, 36};
    vecs[1] = '{"double", 1, 10, 5, 10, 1, C_DOUBLE, 31};
    vecs[2] = '{"held", 2, 60, 0, 0, 1, HELD_CODE, HELD_LAT};
    vecs[3] = '{"glitch", 3, 2, 2, 2, 0, C_NONE, 0};

    keys = '1; rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_state", {single_o, double_o, long_o, ev_valid_o, ev_key_o, ev_code_o, ev_overrun_o}, 18'd0);
    idle(3);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) run_vec(vecs[i]);

    // all four keys clicked together
    idle(10);
    ev_q.delete(); pulse_q.delete();
    s = cyc + 1;
    for (int i = 0; i < 10; i++) cycle(4'hF);
    idle(80);
    chk("par_pulses", pulse_q.size(), 4);
    chk("par_events", ev_q.size(), 4);
    if (pulse_q.size() == 4 && ev_q.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        chk($sformatf("par_pulse_lat%0d", i), pulse_q[i].cyc - s, 36);
        chk($sformatf("par_ev_key%0d", i), ev_q[i].key, i);
        chk($sformatf("par_ev_lat%0d", i), ev_q[i].cyc - s, 37 + i);
        chk($sformatf("par_ev_code%0d", i), ev_q[i].code, C_SINGLE);
      end
    end

    // reset while key0 sits in the inter-click gap
    idle(10);
    for (int i = 0; i < 10; i++) cycle(4'h1);
    idle(8);
    rst_n = 1'b0;
    model_reset();
    #1;
    chk("reset_mid_gap", {single_o, double_o, long_o, ev_valid_o, ev_key_o, ev_code_o, ev_overrun_o}, 18'd0);
    idle(3);
    rst_n = 1'b1;
    ev_q.delete(); pulse_q.delete();
    idle(60);
    chk("no_single_after_reset", pulse_q.size() + ev_q.size(), 0);

    // random key activity: mix of glitches, clicks, doubles and long holds
    lvl = '0;
    for (int k = 0; k < NK; k++) rem[k] = $urandom_range(1, 20);
    for (int i = 0; i < 3000; i++) begin
      for (int k = 0; k < NK; k++) begin
        if (rem[k] == 0) begin
          lvl[k] = ~lvl[k];
          rem[k] = ($urandom_range(0, 9) == 0) ? $urandom_range(30, 70) : $urandom_range(1, 25);
        end
        rem[k]--;
      end
      cycle(lvl);
    end
    idle(100);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/key_gesture.md
# key_gesture

Parametrised multi-key gesture decoder for the piano front end. It synchronises and debounces `NUM_KEYS` active-low push-buttons and classifies each key's activity as single click, double click or long press. Each classification is emitted as a per-key one-cycle pulse. All events are also serialised onto one event port, so simultaneous gestures on different keys are never lost or mis-prioritised downstream. It sits between the board key pins and the note/mode control logic.

## Interface
- `NUM_KEYS`, 4: number of independent keys.
- `DEBOUNCE_MAX`, 999_999: a level must be stable for `DEBOUNCE_MAX+1` cycles to be accepted.
- `GAP_MAX`, 29_999_999: maximum release-to-press gap, in cycles, that still counts as a double click.
- `LONG_MAX`, 49_999_999: hold time, in cycles, that declares a long press.
- `CNT_W`, 32: timer width; must hold `max(GAP_MAX, LONG_MAX)`.
- `clk`  in  1  system clock.
- `rst_n`  in  1  asynchronous, active-low reset.
- `keys`  in  `NUM_KEYS`  raw key pins, active-low (0 = pressed).
- `single_o`  out  `NUM_KEYS`  one-cycle single-click pulse per key.
- `double_o`  out  `NUM_KEYS`  one-cycle double-click pulse per key.
- `long_o`  out  `NUM_KEYS`  one-cycle long-press pulse per key.
- `ev_valid_o`  out  1  one-cycle serialised event strobe.
- `ev_key_o`  out  `$clog2(NUM_KEYS)`  key index of the event.
- `ev_code_o`  out  2  event code: 01 single, 10 double, 11 long.
- `ev_overrun_o`  out  1  one-cycle pulse when an unsent event is overwritten.

## Operation
- Reset value of every output is 0. Per-key clean level resets to released (1). All FSMs reset to IDLE. Timers and pending slots reset to 0.
- **Input conditioning**
  - Each key passes through a 2-FF synchroniser.
  - A debounce counter runs while the synchronised level differs from the clean level. Equality clears the counter.
  - When the counter reaches `DEBOUNCE_MAX`, the clean level flips and a one-cycle press or release strobe fires.
- **Per-key FSM**, driven only by the press/release strobes, with a shared timer `t`:
  - IDLE: on press -> DOWN1, `t`=0.
  - DOWN1: `t`++.
    - Release -> GAP, `t`=0.
    - `t`==`LONG_MAX-1` -> emit LONG, go to HOLD.
  - HOLD: on release -> IDLE. No further event.
  - GAP: `t`++.
    - Press while `t`<`GAP_MAX` -> DOWN2.
    - `t`==`GAP_MAX` -> emit SINGLE, go to IDLE.
    - A press in the same cycle as `t`==`GAP_MAX` counts as DOWN2 (press wins).
  - DOWN2: on release -> emit DOUBLE, go to IDLE. Hold duration in DOWN2 is ignored.
  - A third press arriving after a DOUBLE begins a new gesture from IDLE.
- **Event arbitration**
  - An emitted event sets the key's pending slot (code).
  - Each cycle, the lowest-indexed non-empty slot is presented on the event port and cleared.
  - At most one event is issued per cycle. Other slots wait.
  - If a key emits while its own slot is still full, the new code overwrites the old one and `ev_overrun_o` pulses.
  - An emit and a drain of the same slot in the same cycle: the drained (old) event goes out, the new one is stored, and there is no overrun.
- Timer saturates and never wraps. Arithmetic is unsigned, `CNT_W` wide.
- Reset mid-gesture aborts the gesture and discards pending events silently.

## Timing
- Pin edge to press/release strobe: 2 sync cycles + `DEBOUNCE_MAX+1` stable cycles.
- Per-key pulse outputs are registered and asserted the cycle after the FSM transition that emits them. Each is exactly 1 cycle.
- `ev_valid_o` fires no earlier than the cycle after the per-key pulse. Worst-case wait with all keys firing together is `NUM_KEYS` cycles.
- Single-click decision latency: `GAP_MAX+1` cycles after the release strobe.

## Configuration
- `KEY_LONG_PRESS_EN`
  - Defined: long-press detection as above.
  - Undefined: HOLD state and the LONG path are removed, DOWN1 waits only for release, and `long_o` is tied 0. Code 11 is never issued.

## Structure
- Shared package `key_pkg`: gesture-code localparams (`EV_SINGLE`, `EV_DOUBLE`, `EV_LONG`) and the FSM state enum/localparams.
- Sub-module `key_debounce`: one instance per key, generate loop. Contains the synchroniser, debounce counter, clean level and press/release strobes.
- Top level holds the per-key FSMs, timers, pending slots and fixed-priority arbiter.

## Test plan
Use `DEBOUNCE_MAX`=3, `GAP_MAX`=20, `LONG_MAX`=40.
- Key0 press 10 cycles, release -> `single_o[0]` pulses 21 cycles after the release strobe; event (0, 01).
- Key1 press 10, release 5, press 10, release -> `double_o[1]` once, no single; event (1, 10).
- Key2 held 60 cycles -> `long_o[2]` 40 cycles after the press strobe; no event on release. With the macro undefined, a single is issued instead.
- 2-cycle glitches on key3 -> no strobes, no events.
- Keys 0–3 clicked identically in parallel -> four per-key pulses in the same cycle, then events for keys 0, 1, 2, 3 on consecutive cycles.
- `rst_n` asserted during GAP -> all outputs 0; no single issued after release of reset.
